// File: rtl/mem_data_pkg.sv
// Shared types and helpers for the mem_data word-addressed data memory.
package mem_data_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef logic [DATA_W_DEF-1:0] word_t;

  // Full-width compare so upper address bits never alias into the array.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/mem_data_array.sv
// Storage for mem_data: single-cycle clear, gated synchronous write, combinational read.
module mem_data_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [DATA_W-1:0] word_d, word_q;

    always_comb begin
      word_d = word_q;
      if (we && (idx == AW'(g))) word_d = wdata;
    end

    // Clear wins over a same-cycle write.
    always_ff @(posedge clk) begin
      if (clr) word_q <= '0;
      else     word_q <= word_d;
    end

    assign mem[g] = word_q;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/mem_data.sv
// Word-addressed data memory for the memory stage; range check wraps the array.
// Optional sticky out-of-range write flag: define MEM_DATA_ERR_EN to add port err.
module mem_data
  import mem_data_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              MW,
  input  logic [DATA_W-1:0] datain,
`ifdef MEM_DATA_ERR_EN
  output logic              err,
`endif
  output logic [DATA_W-1:0] dataout
);
  localparam int AW = $clog2(DEPTH);

  logic              in_rng;
  logic              wr_en;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    in_rng  = in_range(64'(addr), 64'(DEPTH));
    idx     = addr[AW-1:0];
    wr_en   = MW && in_rng;
    dataout = in_rng ? rd_data : '0;
  end

  mem_data_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .clr  (rst),
    .we   (wr_en),
    .idx  (idx),
    .wdata(datain),
    .rdata(rd_data)
  );

`ifdef MEM_DATA_ERR_EN
  logic err_d, err_q;

  always_comb err_d = err_q | (MW & ~in_rng);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_mem_data.sv
// Scoreboard bench for mem_data: expected words queued at stimulus, popped at sample.
module tb_mem_data;
  import mem_data_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        MW = 1'b0;
  word_t       datain = '0;
  word_t       dataout;
`ifdef MEM_DATA_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int failures = 0;
  word_t exp_q[$];
  word_t mdl [DEPTH];

  always #5 clk = ~clk;

  mem_data #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .MW     (MW),
    .datain (datain),
`ifdef MEM_DATA_ERR_EN
    .err    (err),
`endif
    .dataout(dataout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare dataout against the oldest queued expectation.
  task automatic pop_chk(input string tag);
    word_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty_q"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk(tag, dataout, e);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input word_t e);
    @(negedge clk);
    addr = a;
    MW   = 1'b0;
    exp_q.push_back(e);
    #1 pop_chk(tag);
  endtask

  task automatic wr(input logic [31:0] a, input word_t d);
    @(negedge clk);
    addr = a; datain = d; MW = 1'b1;
    @(negedge clk);
    MW = 1'b0;
    if (a < DEPTH) mdl[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; MW = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  initial begin
    do_reset();
    rd("rst_a0", 32'd0, 32'h0);
    rd("rst_a1", 32'd1, 32'h0);
    rd("rst_alast", DEPTH - 1, 32'h0);
`ifdef MEM_DATA_ERR_EN
    chk("err_rst", {31'd0, err}, 32'd0);
`endif

    wr(32'd1, 32'hFFFF_FFFF);
    rd("wr_a1", 32'd1, 32'hFFFF_FFFF);
    rd("wr_a0_untouched", 32'd0, 32'h0);

    rd("oor_read", 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    datain = 32'h0101_0101;
    @(negedge clk);
    rd("datain_no_effect", 32'd1, 32'hFFFF_FFFF);

    // Out-of-range write must not alias into word 0 and must be dropped.
    wr(DEPTH, 32'hCAFE_F00D);
    rd("oor_wr_a0", 32'd0, 32'h0);
    rd("oor_wr_read", DEPTH, 32'h0);
`ifdef MEM_DATA_ERR_EN
    chk("err_set", {31'd0, err}, 32'd1);
    rd("err_sticky_rd", 32'd1, 32'hFFFF_FFFF);
    chk("err_sticky", {31'd0, err}, 32'd1);
`endif

    @(negedge clk);
    addr = 32'd2; datain = 32'hA5A5_A5A5; MW = 1'b0;
    repeat (3) @(negedge clk);
    rd("gate_a2", 32'd2, 32'h0);

    // Read-during-write: old word before the edge, new word after.
    wr(32'd3, 32'h1111_1111);
    @(negedge clk);
    addr = 32'd3; datain = 32'h2222_2222; MW = 1'b1;
    exp_q.push_back(32'h1111_1111);
    #1 pop_chk("rdw_before");
    @(posedge clk);
    exp_q.push_back(32'h2222_2222);
    #1 pop_chk("rdw_after");
    @(negedge clk);
    MW = 1'b0;
    mdl[3] = 32'h2222_2222;

    // Multi-cycle MW rewrites current datain each edge.
    @(negedge clk);
    addr = 32'd5; datain = 32'h5555_0001; MW = 1'b1;
    @(negedge clk);
    datain = 32'h5555_0002;
    @(negedge clk);
    MW = 1'b0;
    mdl[5] = 32'h5555_0002;
    rd("multi_mw", 32'd5, 32'h5555_0002);

    // Reset priority over a same-cycle write.
    @(negedge clk);
    rst = 1'b1; MW = 1'b1; addr = 32'd4; datain = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; MW = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rd("rstpri_a4", 32'd4, 32'h0);
    rd("rstpri_a1", 32'd1, 32'h0);
    rd("rstpri_a3", 32'd3, 32'h0);
`ifdef MEM_DATA_ERR_EN
    chk("err_cleared", {31'd0, err}, 32'd0);
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      word_t       d;
      a = ($urandom_range(0, 7) == 0) ? $urandom() | 32'h100 : $urandom_range(0, 15);
      d = $urandom();
      if ($urandom_range(0, 1) == 1) wr(a, d);
      rd("rand", a, (a < DEPTH) ? mdl[a] : 32'h0);
    end
    for (int i = 0; i < 16; i++) rd("sweep", i, mdl[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
